// File: rtl/vga_sprite_pixel_gen_if.sv
// Sprite position update channel (valid/ready) between a position source and vga_sprite_pixel_gen.
// The mirror request exists only when SPRITE_MIRROR_EN is defined.
interface vga_sprite_pixel_gen_if;
    logic [9:0] pos_x;
    logic [9:0] pos_y;
    logic       pos_valid;
    logic       pos_ready;
`ifdef SPRITE_MIRROR_EN
    logic       mirror;

    modport master (output pos_x, output pos_y, output pos_valid, output mirror, input pos_ready);
    modport slave  (input pos_x, input pos_y, input pos_valid, input mirror, output pos_ready);
`else
    modport master (output pos_x, output pos_y, output pos_valid, input pos_ready);
    modport slave  (input pos_x, input pos_y, input pos_valid, output pos_ready);
`endif
endinterface

// File: rtl/vga_sprite_pixel_gen.sv
// Composites one ROM-backed sprite over a solid background, 2-cycle aligned with the syncs.
// Optional horizontal flip is enabled by defining SPRITE_MIRROR_EN.
module vga_sprite_pixel_gen #(
    parameter int unsigned       SPRITE_W    = 16,
    parameter int unsigned       SPRITE_H    = 16,
    parameter int unsigned       ADDR_W      = 8,
    parameter int unsigned       RGB_W       = 12,
    parameter logic [RGB_W-1:0]  TRANSPARENT = 12'hF0F,
    parameter logic [RGB_W-1:0]  BG_COLOR    = 12'h000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [9:0]           x_i,
    input  logic [9:0]           y_i,
    input  logic                 video_on_i,
    input  logic                 hsync_in_i,
    input  logic                 vsync_in_i,
    vga_sprite_pixel_gen_if.slave pos,
    output logic [ADDR_W-1:0]    rom_addr_o,
    input  logic [RGB_W-1:0]     rom_data_i,
    output logic [RGB_W-1:0]     rgb_o,
    output logic                 hsync_o,
    output logic                 vsync_o,
    output logic                 frame_tick_o
);
    localparam int unsigned CX_W     = $clog2(SPRITE_W);
    localparam int unsigned EXT_W    = 11;
    localparam logic [9:0]  HIDE_X   = 10'd640;
    localparam logic [9:0]  HIDE_Y   = 10'd480;
    localparam logic [9:0]  BOUND_Y  = 10'd480;

    logic [9:0]       sx_q, sx_d, sy_q, sy_d;
    logic [9:0]       ax_q, ax_d, ay_q, ay_d;
    logic             pending_q, pending_d;
    logic             tick_q, tick_d;
    logic             hit1_q, hit1_d, von1_q, von1_d, hs1_q, hs1_d, vs1_q, vs1_d;
    logic [RGB_W-1:0] rgb_q, rgb_d;
    logic             hsync_q, hsync_d, vsync_q, vsync_d;
`ifdef SPRITE_MIRROR_EN
    logic             mirror_s_q, mirror_s_d, mirror_a_q, mirror_a_d;
`endif

    logic                  accept;
    logic                  boundary;
    logic                  hit;
    logic [EXT_W-1:0]      x_e, y_e, ax_e, ay_e, dy;
    logic [CX_W-1:0]       cx, cx_sel;
    logic [EXT_W+CX_W-1:0] addr_full;

    // Hit test in 11-bit zero-extended space so a sprite near the edge never wraps.
    always_comb begin
        x_e  = {1'b0, x_i};
        y_e  = {1'b0, y_i};
        ax_e = {1'b0, ax_q};
        ay_e = {1'b0, ay_q};
        hit  = (x_e >= ax_e) && (x_e < ax_e + EXT_W'(SPRITE_W)) &&
               (y_e >= ay_e) && (y_e < ay_e + EXT_W'(SPRITE_H));
        cx   = CX_W'(x_e - ax_e);
        dy   = y_e - ay_e;
`ifdef SPRITE_MIRROR_EN
        cx_sel = mirror_a_q ? (CX_W'(SPRITE_W - 1) - cx) : cx;
`else
        cx_sel = cx;
`endif
        addr_full  = {dy, cx_sel};
        rom_addr_o = hit ? ADDR_W'(addr_full) : '0;
    end

    assign accept         = pos.pos_valid & ~pending_q;
    assign boundary       = (x_i == 10'd0) && (y_i == BOUND_Y);
    assign pos.pos_ready  = ~pending_q;
    assign rgb_o          = rgb_q;
    assign hsync_o        = hsync_q;
    assign vsync_o        = vsync_q;
    assign frame_tick_o   = tick_q;

    // Next-state: shadow/active position handoff and the two pipeline stages.
    always_comb begin
        sx_d      = sx_q;
        sy_d      = sy_q;
        ax_d      = ax_q;
        ay_d      = ay_q;
        pending_d = pending_q;
        tick_d    = 1'b0;
`ifdef SPRITE_MIRROR_EN
        mirror_s_d = mirror_s_q;
        mirror_a_d = mirror_a_q;
`endif
        if (accept) begin
            sx_d      = pos.pos_x;
            sy_d      = pos.pos_y;
            pending_d = 1'b1;
`ifdef SPRITE_MIRROR_EN
            mirror_s_d = pos.mirror;
`endif
        end else if (boundary && pending_q) begin
            ax_d      = sx_q;
            ay_d      = sy_q;
            pending_d = 1'b0;
            tick_d    = 1'b1;
`ifdef SPRITE_MIRROR_EN
            mirror_a_d = mirror_s_q;
`endif
        end

        hit1_d = hit;
        von1_d = video_on_i;
        hs1_d  = hsync_in_i;
        vs1_d  = vsync_in_i;

        if (!von1_q)
            rgb_d = '0;
        else if (hit1_q && (rom_data_i != TRANSPARENT))
            rgb_d = rom_data_i;
        else
            rgb_d = BG_COLOR;
        hsync_d = hs1_q;
        vsync_d = vs1_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sx_q      <= '0;
            sy_q      <= '0;
            ax_q      <= HIDE_X;
            ay_q      <= HIDE_Y;
            pending_q <= 1'b0;
            tick_q    <= 1'b0;
            hit1_q    <= 1'b0;
            von1_q    <= 1'b0;
            hs1_q     <= 1'b1;
            vs1_q     <= 1'b1;
            rgb_q     <= '0;
            hsync_q   <= 1'b1;
            vsync_q   <= 1'b1;
`ifdef SPRITE_MIRROR_EN
            mirror_s_q <= 1'b0;
            mirror_a_q <= 1'b0;
`endif
        end else begin
            sx_q      <= sx_d;
            sy_q      <= sy_d;
            ax_q      <= ax_d;
            ay_q      <= ay_d;
            pending_q <= pending_d;
            tick_q    <= tick_d;
            hit1_q    <= hit1_d;
            von1_q    <= von1_d;
            hs1_q     <= hs1_d;
            vs1_q     <= vs1_d;
            rgb_q     <= rgb_d;
            hsync_q   <= hsync_d;
            vsync_q   <= vsync_d;
`ifdef SPRITE_MIRROR_EN
            mirror_s_q <= mirror_s_d;
            mirror_a_q <= mirror_a_d;
`endif
        end
    end
endmodule

// File: tb/tb_vga_sprite_pixel_gen.sv
// Directed bench for vga_sprite_pixel_gen: drives chosen pixel coordinates and models the sync ROM.
module tb_vga_sprite_pixel_gen;
    localparam logic [11:0] BG = 12'h00A;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [9:0]  x_s, y_s;
    logic        von, hs_in, vs_in;
    logic [7:0]  rom_addr;
    logic [11:0] rom_data = 12'h000;
    logic [11:0] rgb;
    logic        hsync, vsync, frame_tick;
    logic        rom_mode = 1'b0;
    logic [11:0] rom_const = 12'h000;
    int          tests_run = 0;
    int          tests_failed = 0;

    vga_sprite_pixel_gen_if pos_if ();

    vga_sprite_pixel_gen #(.BG_COLOR(BG)) dut (
        .clk(clk), .reset(reset), .x_i(x_s), .y_i(y_s), .video_on_i(von),
        .hsync_in_i(hs_in), .vsync_in_i(vs_in), .pos(pos_if),
        .rom_addr_o(rom_addr), .rom_data_i(rom_data), .rgb_o(rgb),
        .hsync_o(hsync), .vsync_o(vsync), .frame_tick_o(frame_tick)
    );

    always #5 clk = ~clk;

    // Synchronous ROM: word is {1, address} unless a constant is forced.
    always @(posedge clk) rom_data <= rom_mode ? rom_const : {4'h1, rom_addr};

    task automatic idle();
        x_s = 10'd700; y_s = 10'd500; von = 1'b0; hs_in = 1'b1; vs_in = 1'b1;
    endtask

    task automatic probe(input logic [9:0] px, input logic [9:0] py, input logic v,
                         output logic [7:0] a, output logic [11:0] c, output logic hs, output logic vs);
        @(negedge clk);
        x_s = px; y_s = py; von = v; hs_in = 1'b0; vs_in = 1'b0;
        #1 a = rom_addr;
        @(negedge clk);
        idle();
        @(negedge clk);
        c = rgb; hs = hsync; vs = vsync;
    endtask

    task automatic frame_boundary(output logic t1, output logic r1, output logic t2);
        @(negedge clk);
        x_s = 10'd0; y_s = 10'd480; von = 1'b0; hs_in = 1'b1; vs_in = 1'b1;
        @(negedge clk);
        idle();
        t1 = frame_tick; r1 = pos_if.pos_ready;
        @(negedge clk);
        t2 = frame_tick;
    endtask

    task automatic accept(input logic [9:0] px, input logic [9:0] py, input logic m);
        @(negedge clk);
        pos_if.pos_valid = 1'b1; pos_if.pos_x = px; pos_if.pos_y = py;
`ifdef SPRITE_MIRROR_EN
        pos_if.mirror = m;
`else
        if (m) $display("mirror request ignored in this build");
`endif
        @(negedge clk);
        pos_if.pos_valid = 1'b0;
        tests_run++;
        if (pos_if.pos_ready !== 1'b0) begin
            tests_failed++; $display("FAIL accept_ready_low: got %b want 0", pos_if.pos_ready);
        end
    endtask

    task automatic test_reset();
        logic [7:0] a; logic [11:0] c; logic hs, vs, t1, r1, t2;
        accept(10'd10, 10'd10, 1'b0);
        probe(10'd100, 10'd50, 1'b1, a, c, hs, vs);
        tests_run++;
        if (c !== BG || hs !== 1'b0) begin
            tests_failed++; $display("FAIL pre_reset_pixel: got rgb=%h hs=%b want %h 0", c, hs, BG);
        end
        #2 reset = 1'b1;
        #1;
        tests_run++;
        if (rgb !== 12'h000 || hsync !== 1'b1 || vsync !== 1'b1 || pos_if.pos_ready !== 1'b1 || frame_tick !== 1'b0) begin
            tests_failed++;
            $display("FAIL async_reset: got rgb=%h hs=%b vs=%b rdy=%b tick=%b want 000 1 1 1 0",
                     rgb, hsync, vsync, pos_if.pos_ready, frame_tick);
        end
        @(negedge clk); @(negedge clk);
        reset = 1'b0;
        frame_boundary(t1, r1, t2);
        tests_run++;
        if (t1 !== 1'b0) begin
            tests_failed++; $display("FAIL reset_discards_pending: got tick=%b want 0", t1);
        end
        probe(10'd10, 10'd10, 1'b1, a, c, hs, vs);
        tests_run++;
        if (c !== BG || a !== 8'd0) begin
            tests_failed++; $display("FAIL hidden_after_reset: got rgb=%h addr=%0d want %h 0", c, a, BG);
        end
    endtask

    task automatic test_position();
        logic [7:0] a; logic [11:0] c; logic hs, vs, t1, r1, t2;
        accept(10'd100, 10'd50, 1'b0);
        probe(10'd100, 10'd50, 1'b1, a, c, hs, vs);
        tests_run++;
        if (c !== BG) begin
            tests_failed++; $display("FAIL no_tear_before_boundary: got %h want %h", c, BG);
        end
        frame_boundary(t1, r1, t2);
        tests_run++;
        if (t1 !== 1'b1 || t2 !== 1'b0 || r1 !== 1'b1) begin
            tests_failed++; $display("FAIL tick_once: got t1=%b t2=%b rdy=%b want 1 0 1", t1, t2, r1);
        end
        frame_boundary(t1, r1, t2);
        tests_run++;
        if (t1 !== 1'b0) begin
            tests_failed++; $display("FAIL no_tick_idle: got %b want 0", t1);
        end
        probe(10'd100, 10'd50, 1'b1, a, c, hs, vs);
        tests_run++;
        if (a !== 8'd0 || c !== 12'h100 || hs !== 1'b0 || vs !== 1'b0) begin
            tests_failed++; $display("FAIL pix_100_50: got addr=%0d rgb=%h hs=%b vs=%b want 0 100 0 0", a, c, hs, vs);
        end
        probe(10'd115, 10'd65, 1'b1, a, c, hs, vs);
        tests_run++;
        if (a !== 8'd255 || c !== 12'h1FF) begin
            tests_failed++; $display("FAIL pix_115_65: got addr=%0d rgb=%h want 255 1ff", a, c);
        end
        probe(10'd107, 10'd52, 1'b1, a, c, hs, vs);
        tests_run++;
        if (a !== 8'd39 || c !== 12'h127) begin
            tests_failed++; $display("FAIL pix_107_52: got addr=%0d rgb=%h want 39 127", a, c);
        end
        probe(10'd99, 10'd50, 1'b1, a, c, hs, vs);
        tests_run++;
        if (a !== 8'd0 || c !== BG) begin
            tests_failed++; $display("FAIL pix_99_50: got addr=%0d rgb=%h want 0 %h", a, c, BG);
        end
        probe(10'd116, 10'd50, 1'b1, a, c, hs, vs);
        tests_run++;
        if (c !== BG) begin
            tests_failed++; $display("FAIL pix_116_50: got %h want %h", c, BG);
        end
    endtask

    task automatic test_transparent();
        logic [7:0] a; logic [11:0] c; logic hs, vs;
        rom_mode = 1'b1; rom_const = 12'hF0F;
        probe(10'd105, 10'd55, 1'b1, a, c, hs, vs);
        tests_run++;
        if (c !== BG) begin
            tests_failed++; $display("FAIL transparent_key: got %h want %h", c, BG);
        end
        rom_const = 12'h0F0;
        probe(10'd105, 10'd55, 1'b1, a, c, hs, vs);
        tests_run++;
        if (c !== 12'h0F0) begin
            tests_failed++; $display("FAIL opaque_0f0: got %h want 0f0", c);
        end
        probe(10'd105, 10'd55, 1'b0, a, c, hs, vs);
        tests_run++;
        if (c !== 12'h000) begin
            tests_failed++; $display("FAIL blank_in_sprite: got %h want 000", c);
        end
        rom_mode = 1'b0;
    endtask

    task automatic test_clip();
        logic [7:0] a; logic [11:0] c; logic hs, vs, t1, r1, t2;
        accept(10'd632, 10'd470, 1'b0);
        frame_boundary(t1, r1, t2);
        tests_run++;
        if (t1 !== 1'b1) begin
            tests_failed++; $display("FAIL clip_tick: got %b want 1", t1);
        end
        probe(10'd632, 10'd470, 1'b1, a, c, hs, vs);
        tests_run++;
        if (a !== 8'd0 || c !== 12'h100) begin
            tests_failed++; $display("FAIL clip_632_470: got addr=%0d rgb=%h want 0 100", a, c);
        end
        probe(10'd639, 10'd479, 1'b1, a, c, hs, vs);
        tests_run++;
        if (a !== 8'd151 || c !== 12'h197) begin
            tests_failed++; $display("FAIL clip_639_479: got addr=%0d rgb=%h want 151 197", a, c);
        end
        probe(10'd640, 10'd470, 1'b0, a, c, hs, vs);
        tests_run++;
        if (c !== 12'h000) begin
            tests_failed++; $display("FAIL clip_640_blank: got %h want 000", c);
        end
        probe(10'd0, 10'd470, 1'b1, a, c, hs, vs);
        tests_run++;
        if (a !== 8'd0 || c !== BG) begin
            tests_failed++; $display("FAIL no_wrap_x: got addr=%0d rgb=%h want 0 %h", a, c, BG);
        end
        probe(10'd635, 10'd0, 1'b1, a, c, hs, vs);
        tests_run++;
        if (c !== BG) begin
            tests_failed++; $display("FAIL no_wrap_y: got %h want %h", c, BG);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] a; logic [11:0] c; logic hs, vs, t1, r1, t2;
        @(negedge clk);
        pos_if.pos_valid = 1'b1; pos_if.pos_x = 10'd200; pos_if.pos_y = 10'd100;
        @(negedge clk);
        pos_if.pos_x = 10'd300; pos_if.pos_y = 10'd150;
        @(negedge clk);
        tests_run++;
        if (pos_if.pos_ready !== 1'b0) begin
            tests_failed++; $display("FAIL b2b_ready_held_low: got %b want 0", pos_if.pos_ready);
        end
        frame_boundary(t1, r1, t2);
        pos_if.pos_valid = 1'b0;
        tests_run++;
        if (t1 !== 1'b1 || r1 !== 1'b1 || pos_if.pos_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL b2b_boundary: got tick=%b rdy_after=%b rdy_now=%b want 1 1 0", t1, r1, pos_if.pos_ready);
        end
        probe(10'd200, 10'd100, 1'b1, a, c, hs, vs);
        tests_run++;
        if (a !== 8'd0 || c !== 12'h100) begin
            tests_failed++; $display("FAIL b2b_first_active: got addr=%0d rgb=%h want 0 100", a, c);
        end
        probe(10'd300, 10'd150, 1'b1, a, c, hs, vs);
        tests_run++;
        if (c !== BG) begin
            tests_failed++; $display("FAIL b2b_second_not_yet: got %h want %h", c, BG);
        end
        frame_boundary(t1, r1, t2);
        probe(10'd300, 10'd150, 1'b1, a, c, hs, vs);
        tests_run++;
        if (t1 !== 1'b1 || a !== 8'd0 || c !== 12'h100) begin
            tests_failed++; $display("FAIL b2b_second_applied: got tick=%b addr=%0d rgb=%h want 1 0 100", t1, a, c);
        end
        probe(10'd200, 10'd100, 1'b1, a, c, hs, vs);
        tests_run++;
        if (c !== BG) begin
            tests_failed++; $display("FAIL b2b_first_gone: got %h want %h", c, BG);
        end
    endtask

`ifdef SPRITE_MIRROR_EN
    task automatic test_mirror();
        logic [7:0] a; logic [11:0] c; logic hs, vs, t1, r1, t2;
        accept(10'd0, 10'd0, 1'b1);
        pos_if.mirror = 1'b0;
        frame_boundary(t1, r1, t2);
        probe(10'd0, 10'd0, 1'b1, a, c, hs, vs);
        tests_run++;
        if (a !== 8'd15 || c !== 12'h10F) begin
            tests_failed++; $display("FAIL mirror_0_0: got addr=%0d rgb=%h want 15 10f", a, c);
        end
        probe(10'd15, 10'd0, 1'b1, a, c, hs, vs);
        tests_run++;
        if (a !== 8'd0) begin
            tests_failed++; $display("FAIL mirror_15_0: got addr=%0d want 0", a);
        end
    endtask
`endif

    initial begin
        idle();
        pos_if.pos_valid = 1'b0; pos_if.pos_x = 10'd0; pos_if.pos_y = 10'd0;
`ifdef SPRITE_MIRROR_EN
        pos_if.mirror = 1'b0;
`endif
        repeat (3) @(negedge clk);
        reset = 1'b0;
        test_reset();
        test_position();
        test_transparent();
        test_clip();
        test_back_to_back();
`ifdef SPRITE_MIRROR_EN
        test_mirror();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
